ncl_phase_sequencer: RTL
========================

# ncl_phase_sequencer

Clocked phase sequencer for a dual-rail NULL-convention (self-timed) datapath such as the 24-bit dual-rail incrementer. It drives the datapath operand bus through HIGH-NULL, LOW-NULL and DATA wavefronts, detects completion on the datapath outputs, and synchronises the completion flags into `clk`. It captures each DATA result, feeds it back as the next operand, and reports progress and timeouts. It replaces the latch-based combinational phase control and sits between the serial test harness and the datapath.

## Interface
- `WIDTH`, 48, dual-rail bus width; must be even. Pair (2i+1, 2i) encodes one logical bit: 2'b10 = 1, 2'b01 = 0, 2'b11 = HIGH-NULL, 2'b00 = LOW-NULL.
- `SYNC_STAGES`, 2, synchroniser depth for completion flags; minimum 2.
- `TIMEOUT_CYCLES`, 1023, maximum cycles allowed per phase.
- `CNT_BITS`, 32, width of `run_len` and `iter_count`.

Ports:
- `clk`  in  1  single clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  begin run; sampled in IDLE or ERROR.
- `stop`  in  1  request graceful stop; level or pulse.
- `seed_load`  in  1  load `seed` into operand register; honoured in IDLE only.
- `seed`  in  WIDTH  dual-rail operand to load.
- `run_len`  in  CNT_BITS  iterations per run, sampled at start; 0 = run until stop.
- `dr_inputs`  out  WIDTH  operand/NULL bus to datapath, registered.
- `dr_outputs`  in  WIDTH  datapath outputs, asynchronous to `clk`.
- `result`  out  WIDTH  last captured DATA result.
- `result_valid`  out  1  one-cycle pulse per captured result.
- `iter_count`  out  CNT_BITS  results captured since last start.
- `phase`  out  2  0 IDLE, 1 HNULL, 2 LNULL, 3 DATA; holds the failing phase while in ERROR.
- `busy`  out  1  high in HNULL, LNULL, DATA.
- `timeout_err`  out  1  sticky; high in ERROR.

## Operation
- Raw detectors on `dr_outputs`:
  - `hn` = all bits 1.
  - `ln` = all bits 0.
  - `dv` = every pair has differing bits.
- Each detector passes through its own SYNC_STAGES flop chain. Only the synchronised flags reach the FSM.
- States:
  - IDLE: `dr_inputs` = all ones.
  - HNULL: `dr_inputs` = all ones; waits for synced `hn`, then goes to LNULL.
  - LNULL: `dr_inputs` = all zeros; waits for synced `ln`, then goes to DATA.
  - DATA: `dr_inputs` = operand; waits for synced `dv`, then captures.
  - ERROR.
- IDLE --start--> HNULL. On entry to HNULL, clear `iter_count` and `stop_pending`, and latch `run_len`.
- Capture, on the DATA exit edge:
  - `result` <= `dr_outputs` and operand <= `dr_outputs`.
  - `iter_count` += 1.
  - `result_valid` = 1 for the next cycle.
  - Next state: IDLE if `stop_pending`, or if `run_len`≠0 and the new `iter_count` == `run_len`; otherwise HNULL.
- Blanking: flags are ignored for the first SYNC_STAGES+1 cycles after any phase entry, so stale synchronised values cannot advance the FSM.
- Phase timer: cleared on phase entry and incremented each cycle. If it reaches TIMEOUT_CYCLES without an advance: go to ERROR, assert `timeout_err`, freeze `phase`, set `dr_inputs` = all ones.
- ERROR --start--> HNULL, clearing `timeout_err`. Only `start` or reset leaves ERROR.
- `stop` while busy sets `stop_pending`. The current iteration completes through capture, then the FSM goes to IDLE. `stop` in IDLE is ignored.
- `start` while busy is ignored. `seed_load` outside IDLE is ignored. `seed_load` and `start` in the same IDLE cycle: the seed is loaded and used.
- Reset values:
  - FSM state IDLE, `phase`=0, `busy`=0.
  - `dr_inputs` = all ones.
  - Operand = {WIDTH/2{2'b01}} (logical 0), `result` = same.
  - `result_valid`=0, `iter_count`=0, `timeout_err`=0.
  - Synchroniser flops 0, `stop_pending`=0.

## Timing
- `start` sampled at edge N: `phase`=1 and `dr_inputs`=all ones from N+1.
- Completion latency: the datapath raw flag becomes valid before edge M. The FSM advances at edge M+SYNC_STAGES, or at the end of blanking if that is later. New `dr_inputs` appear at that same edge.
- Minimum iteration = 3×(SYNC_STAGES+2) cycles.
- `result` and `iter_count` update on the capture edge. `result_valid` is high exactly the cycle after that edge.
- Flag and timeout in the same cycle: flag wins.
- `rst_n` low at any edge, including mid-phase: all reset values take effect at that edge.
- `iter_count` wraps modulo 2^CNT_BITS. With `run_len`=0 there is no stop on wrap.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles → `phase`=0, `busy`=0, `dr_inputs`=48'hFFFF_FFFF_FFFF, `result`=48'h5555_5555_5555, `iter_count`=0.
- Run: datapath model = dual-rail incrementer, 4-cycle delay; seed logical 5, `run_len`=3, pulse `start` → exactly 3 `result_valid` pulses with logical results 6, 7, 8; then IDLE, `iter_count`=3, `busy`=0.
- Wrap: seed logical 24'hFFFFFF, `run_len`=1 → `result` = logical 0 (48'h5555_5555_5555).
- Stop: `run_len`=0, assert `stop` during the second LNULL → second result captured, then IDLE with `iter_count`=2.
- Timeout: TIMEOUT_CYCLES=16, model never makes `dv` true → ERROR 16 cycles after DATA entry, `timeout_err`=1, `phase`=3, `dr_inputs`=all ones. A later `start` clears `timeout_err` and enters HNULL.
- Reset mid-DATA, plus stale flag: assert `rst_n`=0 during DATA → reset values next edge. Hold model `hn`=1 across the restart → no HNULL→LNULL advance before SYNC_STAGES+1 cycles have elapsed.

Source files
------------

// File: rtl/ncl_phase_sequencer.sv
// Clocked HIGH-NULL / LOW-NULL / DATA phase sequencer for a dual-rail NCL datapath.
// Completion flags are synchronised into clk; each DATA result is captured and fed back as the next operand.
module ncl_phase_sequencer #(
  parameter int unsigned WIDTH          = 48,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1023,
  parameter int unsigned CNT_BITS       = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                stop,
  input  logic                seed_load,
  input  logic [WIDTH-1:0]    seed,
  input  logic [CNT_BITS-1:0] run_len,
  output logic [WIDTH-1:0]    dr_inputs,
  input  logic [WIDTH-1:0]    dr_outputs,
  output logic [WIDTH-1:0]    result,
  output logic                result_valid,
  output logic [CNT_BITS-1:0] iter_count,
  output logic [1:0]          phase,
  output logic                busy,
  output logic                timeout_err
);

  localparam int unsigned PAIRS = WIDTH / 2;
  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + SYNC_STAGES + 2);
  localparam logic [TMR_W-1:0] BLANK_END  = TMR_W'(SYNC_STAGES + 1);
  localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [WIDTH-1:0] ALL_ONES   = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] LOGIC_ZERO = {PAIRS{2'b01}};

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HNULL = 3'd1;
  localparam logic [2:0] S_LNULL = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_ERROR = 3'd4;

  logic [2:0]             state_q, state_d;
  logic [TMR_W-1:0]       tmr_q, tmr_d;
  logic [WIDTH-1:0]       operand_q, operand_d;
  logic [WIDTH-1:0]       result_q, result_d;
  logic [WIDTH-1:0]       dr_in_q, dr_in_d;
  logic [CNT_BITS-1:0]    iter_q, iter_d;
  logic [CNT_BITS-1:0]    run_len_q, run_len_d;
  logic [1:0]             phase_q, phase_d;
  logic                   rv_q, rv_d;
  logic                   busy_q, busy_d;
  logic                   to_q, to_d;
  logic                   stop_pending_q, stop_pending_d;
  logic [SYNC_STAGES-1:0] hn_sync_q, ln_sync_q, dv_sync_q;

  logic                   hn_raw, ln_raw, dv_raw;
  logic                   hn_s, ln_s, dv_s;
  logic                   unblank, tmo, in_busy;
  logic [CNT_BITS-1:0]    iter_inc;

  // Raw completion detectors on the asynchronous datapath outputs
  always_comb begin
    hn_raw = &dr_outputs;
    ln_raw = ~|dr_outputs;
    dv_raw = 1'b1;
    for (int i = 0; i < int'(PAIRS); i++) begin
      dv_raw = dv_raw & (dr_outputs[2*i] ^ dr_outputs[2*i+1]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hn_sync_q <= '0;
      ln_sync_q <= '0;
      dv_sync_q <= '0;
    end else begin
      hn_sync_q <= {hn_sync_q[SYNC_STAGES-2:0], hn_raw};
      ln_sync_q <= {ln_sync_q[SYNC_STAGES-2:0], ln_raw};
      dv_sync_q <= {dv_sync_q[SYNC_STAGES-2:0], dv_raw};
    end
  end

  assign hn_s = hn_sync_q[SYNC_STAGES-1];
  assign ln_s = ln_sync_q[SYNC_STAGES-1];
  assign dv_s = dv_sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      tmr_q          <= '0;
      operand_q      <= LOGIC_ZERO;
      result_q       <= LOGIC_ZERO;
      dr_in_q        <= ALL_ONES;
      iter_q         <= '0;
      run_len_q      <= '0;
      phase_q        <= 2'd0;
      rv_q           <= 1'b0;
      busy_q         <= 1'b0;
      to_q           <= 1'b0;
      stop_pending_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      tmr_q          <= tmr_d;
      operand_q      <= operand_d;
      result_q       <= result_d;
      dr_in_q        <= dr_in_d;
      iter_q         <= iter_d;
      run_len_q      <= run_len_d;
      phase_q        <= phase_d;
      rv_q           <= rv_d;
      busy_q         <= busy_d;
      to_q           <= to_d;
      stop_pending_q <= stop_pending_d;
    end
  end

  // Next-state and registered-output logic; blanking gates every flag after a phase entry
  always_comb begin
    state_d        = state_q;
    tmr_d          = tmr_q;
    operand_d      = operand_q;
    result_d       = result_q;
    iter_d         = iter_q;
    run_len_d      = run_len_q;
    rv_d           = 1'b0;
    stop_pending_d = stop_pending_q;
    in_busy        = (state_q == S_HNULL) || (state_q == S_LNULL) || (state_q == S_DATA);
    unblank        = (tmr_q >= BLANK_END);
    tmo            = (tmr_q == TMR_LAST);
    iter_inc       = iter_q + CNT_BITS'(1);

    if (in_busy && stop) stop_pending_d = 1'b1;

    case (state_q)
      S_IDLE, S_ERROR: begin
        if (seed_load && (state_q == S_IDLE)) operand_d = seed;
        if (start) begin
          state_d        = S_HNULL;
          iter_d         = '0;
          stop_pending_d = 1'b0;
          run_len_d      = run_len;
        end
      end
      S_HNULL: begin
        if (unblank && hn_s) state_d = S_LNULL;
        else if (tmo)        state_d = S_ERROR;
      end
      S_LNULL: begin
        if (unblank && ln_s) state_d = S_DATA;
        else if (tmo)        state_d = S_ERROR;
      end
      S_DATA: begin
        if (unblank && dv_s) begin
          result_d  = dr_outputs;
          operand_d = dr_outputs;
          iter_d    = iter_inc;
          rv_d      = 1'b1;
          if (stop_pending_q || stop || ((run_len_q != '0) && (iter_inc == run_len_q)))
            state_d = S_IDLE;
          else
            state_d = S_HNULL;
        end else if (tmo) begin
          state_d = S_ERROR;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q) tmr_d = '0;
    else if (in_busy)       tmr_d = tmr_q + TMR_W'(1);

    case (state_d)
      S_LNULL: dr_in_d = '0;
      S_DATA:  dr_in_d = operand_d;
      default: dr_in_d = ALL_ONES;
    endcase

    phase_d = (state_d == S_ERROR) ? phase_q : state_d[1:0];
    busy_d  = (state_d == S_HNULL) || (state_d == S_LNULL) || (state_d == S_DATA);
    to_d    = (state_d == S_ERROR);
  end

  assign dr_inputs    = dr_in_q;
  assign result       = result_q;
  assign result_valid = rv_q;
  assign iter_count   = iter_q;
  assign phase        = phase_q;
  assign busy         = busy_q;
  assign timeout_err  = to_q;

endmodule
